pipeline_stall_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Merges four conditions into one set of per-stage enable, flush and bubble controls:
  - load-use hazard;
  - taken branch resolved in EX;
  - multi-cycle mult/div occupying EX;
  - data-memory wait.
- Sits beside the pipeline registers. Drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables, plus the IF/ID flush and ID/EX bubble insertion.

---
 rtl/pipeline_stall_ctrl_if.sv | 32 +++
 rtl/pipeline_stall_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and per-stage pipeline controls exchanged between the stall
// sequencer (master) and the pipeline datapath (slave).
interface pipeline_stall_ctrl_if;
    logic        mem_read_ex;
    logic [4:0]  rt_ex;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        branch_taken_ex;
    logic        md_start_id;
    logic        dmem_busy;
    logic        en_pc;
    logic        en_if_id;
    logic        en_id_ex;
    logic        en_ex_mem;
    logic        en_mem_wb;
    logic        flush_if_id;
    logic        bubble_id_ex;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        input  mem_read_ex, rt_ex, rs_id, rt_id, branch_taken_ex, md_start_id, dmem_busy,
        output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
        output flush_if_id, bubble_id_ex, md_busy, stall_cycles
    );

    modport slave (
        output mem_read_ex, rt_ex, rs_id, rt_id, branch_taken_ex, md_start_id, dmem_busy,
        input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
        input  flush_if_id, bubble_id_ex, md_busy, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; STALL_CNT_EN adds a
// saturating counter of cycles in which the PC was held.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; resolves freeze, branch flush, load-use stall
// MD_BUSY | mult/div owns EX; front end held while the down-counter runs
module pipeline_stall_ctrl #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_stall_ctrl_if.master bus
);
    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_LAT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              lu;
    logic              en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic              flush_if_id, bubble_id_ex, md_busy;

    assign lu = bus.mem_read_ex && (bus.rt_ex != 5'd0) &&
                ((bus.rt_ex == bus.rs_id) || (bus.rt_ex == bus.rt_id));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        en_pc        = 1'b1;
        en_if_id     = 1'b1;
        en_id_ex     = 1'b1;
        en_ex_mem    = 1'b1;
        en_mem_wb    = 1'b1;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        md_busy      = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (bus.dmem_busy) begin
                        en_pc     = 1'b0;
                        en_if_id  = 1'b0;
                        en_id_ex  = 1'b0;
                        en_ex_mem = 1'b0;
                        en_mem_wb = 1'b0;
                    end else if (bus.branch_taken_ex) begin
                        // ID instruction is squashed, so its hazards are moot
                        flush_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                    end else if (lu) begin
                        en_pc        = 1'b0;
                        en_if_id     = 1'b0;
                        bubble_id_ex = 1'b1;
                    end else if (bus.md_start_id) begin
                        state_nxt = MD_BUSY;
                        cnt_nxt   = MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (bus.dmem_busy) begin
                        en_pc     = 1'b0;
                        en_if_id  = 1'b0;
                        en_id_ex  = 1'b0;
                        en_ex_mem = 1'b0;
                        en_mem_wb = 1'b0;
                    end else begin
                        en_pc        = 1'b0;
                        en_if_id     = 1'b0;
                        bubble_id_ex = 1'b1;
                        if (cnt == '0) begin
                            state_nxt = RUN;
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.en_pc        = en_pc;
    assign bus.en_if_id     = en_if_id;
    assign bus.en_id_ex     = en_id_ex;
    assign bus.en_ex_mem    = en_ex_mem;
    assign bus.en_mem_wb    = en_mem_wb;
    assign bus.flush_if_id  = flush_if_id;
    assign bus.bubble_id_ex = bubble_id_ex;
    assign bus.md_busy      = md_busy;

`ifdef STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!en_pc && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = 32'd0;
`endif
endmodule
